// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access to a word-wide data memory.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_range,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mis_q;
  logic        rng_q;
  logic [31:0] word_q;

  logic accept;
  logic mis_in;
  logic rng_in;
  logic err_in;
  logic ws_in;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    mis_in = 1'b0;
    case (req_size)
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = req_addr[0];
      2'b10:   mis_in = |req_addr[1:0];
      default: mis_in = 1'b1;
    endcase
    rng_in = !mis_in &&
      ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    err_in = mis_in || rng_in;
    ws_in  = req_we && (req_size == 2'b10);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      word_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mis_q   <= mis_in;
        rng_q   <= rng_in;
      end
      if (state == READ) begin
        word_q <= mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            err_in:            state_nx = RESP;
            (!err_in && ws_in): state_nx = WRITE;
            default:           state_nx = READ;
          endcase
        end
      end
      READ:  state_nx = we_q ? WRITE : RESP;
      WRITE: state_nx = RESP;
      RESP:  state_nx = IDLE;
    endcase
  end

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [31:0] mask;
  logic [31:0] store_word;

  always_comb begin
    sh   = {addr_q[1:0], 3'b000};
    lane = word_q >> sh;
    load_ext = word_q;
    mask = 32'h0000_00ff;
    case (size_q)
      2'b00: begin
        load_ext = uns_q ? {24'h0, lane[7:0]}
                         : {{24{lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        mask = 32'h0000_ffff;
        load_ext = uns_q ? {16'h0, lane[15:0]}
                         : {{16{lane[15]}}, lane[15:0]};
      end
      default: load_ext = word_q;
    endcase
    // Lane merge only matters for sub-word stores
    if (size_q == 2'b10) begin
      store_word = wdata_q;
    end else begin
      store_word = (word_q & ~(mask << sh)) |
                   ((wdata_q & mask) << sh);
    end
  end

  always_comb begin
    req_ready      = (state == IDLE);
    rsp_valid      = (state == RESP);
    mem_we         = (state == WRITE);
    mem_a          = 32'h0;
    mem_wd         = 32'h0;
    rsp_rdata      = 32'h0;
    rsp_misaligned = 1'b0;
    rsp_range      = 1'b0;
    if (state != IDLE) begin
      mem_a = {addr_q[31:2], 2'b00};
    end
    if (state == WRITE) begin
      mem_wd = store_word;
    end
    if (state == RESP) begin
      rsp_misaligned = mis_q;
      rsp_range      = rng_q;
      if (!we_q && !mis_q && !rng_q) begin
        rsp_rdata = load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached memory, transaction model,
// per-cycle compare against model timeline, directed scenarios.
module tb_load_store_unit;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_range;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned),
    .rsp_range(rsp_range),
    .mem_we(mem_we),
    .mem_a(mem_a),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];

  assign mem_rd = (mem_a[31:8] == 24'h0) ? mem[mem_a[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_a[31:8] == 24'h0) mem[mem_a[7:2]] <= mem_wd;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n++;

  int acc_at = -100;
  int rsp_at = -100;
  int we_at  = -100;
  logic [31:0] exp_rd, exp_wd, exp_a;
  logic exp_mis, exp_rng;
  bit checking = 0;

  int we_pulses = 0;
  logic [31:0] last_rd, last_wd;
  logic last_mis, last_rng;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h (edge %0d)",
               name, act, exp, edge_n);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (edge %0d)",
               name, act, exp, edge_n);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit v, w, r;
    if (checking) begin
      v = (edge_n == rsp_at);
      w = (edge_n == we_at);
      r = !(edge_n >= acc_at && edge_n <= rsp_at);
      chk1("rsp_valid", rsp_valid, v);
      chk1("req_ready", req_ready, r);
      chk1("mem_we", mem_we, w);
      chk("rsp_rdata", rsp_rdata, v ? exp_rd : 32'h0);
      chk1("rsp_misaligned", rsp_misaligned, v ? exp_mis : 1'b0);
      chk1("rsp_range", rsp_range, v ? exp_rng : 1'b0);
      chk("mem_a", mem_a, r ? 32'h0 : exp_a);
      if (w) chk("mem_wd", mem_wd, exp_wd);
    end
    if (rsp_valid) begin
      last_rd  = rsp_rdata;
      last_mis = rsp_misaligned;
      last_rng = rsp_range;
    end
    if (mem_we) begin
      we_pulses++;
      last_wd = mem_wd;
    end
  end

  // Called and returns at negedge+1; leaves in the first busy cycle.
  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    int guard;
    logic [31:0] w, nw;
    longint val, m;
    int off, nb, lat;
    bit mis, rng, err;
    guard = 0;
    while (req_ready !== 1'b1) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL issue_timeout: got ready=%b want 1", req_ready);
        return;
      end
    end
    mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
          (sz == 2'd2 && a % 4 != 0);
    rng = !mis && ((a >> 2) >= MW);
    err = mis || rng;
    off = int'(a % 4);
    nb  = 1 << sz;
    w   = 32'h0;
    val = 0;
    nw  = 32'h0;
    if (!err) begin
      w = ref_mem[a[7:2]];
      if (sz == 2'd2) begin
        val = longint'(w);
        nw  = wd;
      end else begin
        val = (longint'(w) >> (8 * off)) % (longint'(1) << (8 * nb));
        if (!uns && val >= (longint'(1) << (8 * nb - 1)))
          val = val - (longint'(1) << (8 * nb));
        m  = ((longint'(1) << (8 * nb)) - 1) << (8 * off);
        nw = 32'((longint'(w) & ~m) | ((longint'(wd) << (8 * off)) & m));
      end
    end
    lat = err ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
    exp_rd  = (!we && !err) ? 32'(val) : 32'h0;
    exp_mis = mis;
    exp_rng = rng;
    exp_wd  = nw;
    exp_a   = a & 32'hFFFF_FFFC;
    if (we && !err) ref_mem[a[7:2]] = nw;
    last_rd = 32'hxxxx_xxxx;
    acc_at = edge_n + 1;
    rsp_at = acc_at + lat - 1;
    we_at  = (we && !err) ? rsp_at - 1 : -100;
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (edge_n <= rsp_at) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_timeout: got edge %0d want > %0d",
                 edge_n, rsp_at);
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int wp;
    logic [31:0] saved;
    for (int i = 0; i < MW; i++) begin
      mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A00_00A5;
    end
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h0000_80F0;
    mem[2] = 32'h8899_AABB;
    mem[MW-1] = 32'hCAFE_F00D;
    for (int i = 0; i < MW; i++) ref_mem[i] = mem[i];

    #3;
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_mis", rsp_misaligned, 1'b0);
    chk1("rst_rng", rsp_range, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    checking = 1;
    @(negedge clk); #1;

    issue(0, 2'd2, 0, 32'h0, 0); wait_done();
    chk("lw0", last_rd, 32'h1111_1111);
    chk1("lw0_mis", last_mis, 1'b0);
    chk1("lw0_rng", last_rng, 1'b0);

    issue(0, 2'd0, 0, 32'h4, 0); wait_done();
    chk("lb4", last_rd, 32'hFFFF_FFF0);
    issue(0, 2'd1, 1, 32'h4, 0); wait_done();
    chk("lhu4", last_rd, 32'h0000_80F0);
    issue(0, 2'd1, 0, 32'h4, 0); wait_done();
    chk("lh4", last_rd, 32'hFFFF_80F0);
    issue(0, 2'd0, 0, 32'h5, 0); wait_done();
    chk("lb5", last_rd, 32'hFFFF_FF80);
    issue(0, 2'd0, 1, 32'h7, 0); wait_done();
    chk("lbu7", last_rd, 32'h0);
    issue(0, 2'd1, 0, 32'hA, 0); wait_done();
    chk("lh10", last_rd, 32'hFFFF_8899);

    wp = we_pulses;
    issue(1, 2'd0, 0, 32'h2, 32'h0000_00AB); wait_done();
    chk("sb_pulses", 32'(we_pulses - wp), 32'd1);
    chk("sb_wd", last_wd, 32'h11AB_1111);
    issue(0, 2'd2, 0, 32'h0, 0); wait_done();
    chk("lw0_after_sb", last_rd, 32'h11AB_1111);

    issue(1, 2'd1, 0, 32'h6, 32'hFFFF_1234); wait_done();
    issue(1, 2'd2, 0, 32'hC, 32'hDEAD_BEEF); wait_done();
    issue(0, 2'd2, 0, 32'hFC, 0); wait_done();
    chk("lw_last", last_rd, 32'hCAFE_F00D);

    wp = we_pulses;
    issue(0, 2'd2, 0, 32'h6, 0); wait_done();
    chk1("lw6_mis", last_mis, 1'b1);
    chk1("lw6_rng", last_rng, 1'b0);
    issue(0, 2'd2, 0, 32'h100, 0); wait_done();
    chk1("lw100_rng", last_rng, 1'b1);
    chk1("lw100_mis", last_mis, 1'b0);
    issue(0, 2'd1, 0, 32'h101, 0); wait_done();
    chk1("lh101_mis", last_mis, 1'b1);
    chk1("lh101_rng", last_rng, 1'b0);
    issue(1, 2'd3, 0, 32'h8, 32'h1); wait_done();
    issue(1, 2'd2, 0, 32'h200, 32'h1); wait_done();
    issue(1, 2'd0, 0, 32'h103, 32'h1); wait_done();
    chk("err_no_write", 32'(we_pulses - wp), 32'd0);

    wp = we_pulses;
    saved = ref_mem[2];
    issue(1, 2'd0, 0, 32'h9, 32'h0000_0055);
    reset_n = 1'b0;
    ref_mem[2] = saved;
    acc_at = -100;
    rsp_at = -100;
    we_at  = -100;
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk1("ready_after_rst", req_ready, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("rst_no_write", 32'(we_pulses - wp), 32'd0);

    wp = we_pulses;
    issue(0, 2'd2, 0, 32'h10, 0);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'd2;
    req_addr = 32'h14;
    req_wdata = 32'hBAD0_BAD0;
    @(negedge clk); #1;
    req_addr = 32'h18;
    issue(0, 2'd2, 0, 32'h20, 0); wait_done();
    chk("hold_no_write", 32'(we_pulses - wp), 32'd0);

    for (int i = 0; i < MW; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    chk("mem0_final", mem[0], 32'h11AB_1111);
    chk("mem1_final", mem[1], 32'h1234_80F0);
    chk("mem3_final", mem[3], 32'hDEAD_BEEF);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core access request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_misaligned  output  1  error: misaligned or illegal size.
REQ-014 SHALL have port rsp_range  output  1  error: word index >= MEM_WORDS.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_a  output  32  memory byte address, always word-aligned (bits[1:0] = 00).
REQ-017 SHALL have port mem_wd  output  32  memory write data.
REQ-018 SHALL have port mem_rd  input  32  memory read data, combinational from mem_a.

Function
REQ-019 SHALL implement states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on a posedge with req_valid && req_ready, latching all req_* fields.
REQ-021 SHALL flag misaligned when: size 01 with addr[0]=1; size 10 with addr[1:0]!=00; size 11 for any address.
REQ-022 SHALL flag out-of-range when addr[31:2] >= MEM_WORDS; misaligned takes priority, and only one error flag is set per response.
REQ-023 SHALL transition IDLE->RESP on accept of an erroring request, with no memory write.
REQ-024 SHALL transition IDLE->READ on accept of a load or a sub-word store, and IDLE->WRITE on accept of a word store.
REQ-025 SHALL, in READ, drive mem_a = {addr[31:2],2'b00} and latch mem_rd at the clock edge; a load then goes to RESP, a sub-word store goes to WRITE.
REQ-026 SHALL, in WRITE, assert mem_we for exactly one cycle with mem_wd = req_wdata (word store) or the latched word with only the addressed byte/halfword lane replaced (sub-word store), then go to RESP.
REQ-027 SHALL, in RESP, assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-028 SHALL have these latencies from the accept edge to the cycle with rsp_valid high: load 2, word store 2, sub-word store 3, error 1.
REQ-029 SHALL select the load lane from addr[1:0] (byte lane = addr[1:0], halfword lane = addr[1]) and extend it to 32 bits per req_unsigned.
REQ-030 SHALL keep rsp_rdata, rsp_misaligned and rsp_range stable and valid only while rsp_valid = 1, and 0 otherwise.
REQ-031 SHALL keep mem_we = 0 in IDLE, READ and RESP; mem_a SHALL hold the latched aligned address outside IDLE and be 0 in IDLE.
REQ-032 SHALL ignore req_valid and all req_* inputs while req_ready = 0.

Reset
REQ-033 SHALL, on reset_n low, immediately force state IDLE, mem_we 0, mem_a 0, mem_wd 0, rsp_valid 0, rsp_rdata 0, rsp_misaligned 0, rsp_range 0, and all latched request fields 0.
REQ-034 SHALL, if reset_n asserts during READ or WRITE, abandon the access with no partial or later write, and produce no response after release.
REQ-035 SHALL, after reset_n deasserts, report req_ready = 1 on the first clock edge.

Verification
REQ-036 SHALL cover this scenario: memory word 0 = 0x11111111; load word addr 0x0 -> rsp_valid 2 cycles after accept, rsp_rdata 0x11111111, both error flags 0.
REQ-037 SHALL cover this scenario: word 1 = 0x000080F0; signed byte load at 0x4 -> 0xFFFFFFF0; unsigned halfword load at 0x4 -> 0x000080F0.
REQ-038 SHALL cover this scenario: word 0 = 0x11111111; byte store of 0xAB at addr 0x2 -> exactly one mem_we pulse with mem_wd 0x11AB1111, response 3 cycles after accept.
REQ-039 SHALL cover this scenario: word load at 0x6 -> rsp_misaligned 1 one cycle after accept, no mem_we; word load at 0x100 (MEM_WORDS 64) -> rsp_range 1, no mem_we.
REQ-040 SHALL cover this scenario: sub-word store with reset_n pulsed low during READ -> mem_we never asserts, no rsp_valid, req_ready = 1 on the first edge after release.
REQ-041 SHALL cover this scenario: req_valid held high with changing req_addr across a 2-cycle load -> only the first request is served; the next is accepted only in IDLE.
